bram_input_pingpong: RTL and testbench
======================================

Name: bram_input_pingpong

Overview:
Double-buffered (ping-pong) input feature-map buffer for the conv datapath. A byte-serial producer fills one bank in channel-fastest order while the compute engine reads full pixels (all channels in one word) from the other bank. Per-bank full/empty tracking and a release handshake let frame N+1 load while frame N is consumed. Out-of-range reads return zero for padding.

Parameters:
DATA_WIDTH, 8, bits per channel sample
IN_CHANNELS, 3, channels per pixel
IN_WIDTH, 4, feature-map width in pixels
IN_HEIGHT, 4, feature-map height in pixels
OUTPUT_REGISTER, "false", "true" adds one output pipeline register
(derived) NPIX = IN_WIDTH*IN_HEIGHT; PIX_AW = $clog2(NPIX)+1

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_data  in  DATA_WIDTH  one channel sample
wr_valid  in  1  wr_data valid
wr_ready  out  1  buffer accepts wr_data this cycle
wr_frame_done  out  1  1-cycle pulse: last sample of a frame accepted
rd_bank_ready  out  1  a full bank is available to read
rd_addr  in  PIX_AW  pixel index y*IN_WIDTH+x
rd_en  in  1  read request
rd_data  out  DATA_WIDTH*IN_CHANNELS  pixel; channel c at [(c+1)*DATA_WIDTH-1 -: DATA_WIDTH]
rd_valid  out  1  rd_data valid
rd_release  in  1  pulse: reader done with current bank
full_count  out  2  number of full banks (0..2)

Behaviour:
- Storage: 2 banks x NPIX words x DATA_WIDTH*IN_CHANNELS bits, synchronous-read RAM.
- Write side: ch_cnt (0..IN_CHANNELS-1), pix_cnt (0..NPIX-1), wr_bank pointer. Accept when wr_valid && wr_ready. Each accepted sample is shifted into a pixel assembly register at lane ch_cnt. On the last channel, the assembled word (including the current sample) is written to bank wr_bank at address pix_cnt in that same cycle, then ch_cnt is cleared and pix_cnt increments.
- On the last channel of pixel NPIX-1: pulse wr_frame_done, toggle wr_bank, clear counters, full_count += 1.
- wr_ready = (full_count != 2). Samples presented while wr_ready=0 are not consumed; the producer holds them.
- Read side: rd_bank pointer; rd_bank_ready = (full_count != 0).
- A read is effective when rd_en && rd_bank_ready && rd_addr < NPIX. Data comes from bank rd_bank.
- OUTPUT_REGISTER="false": rd_data/rd_valid update 1 cycle after the request. "true": 2 cycles.
- rd_en=1 with rd_addr >= NPIX: rd_data=0, rd_valid=1 at the same latency (zero padding).
- rd_en=0, or rd_en=1 with rd_bank_ready=0: rd_data=0, rd_valid=0 at the same latency.
- Fully pipelined: one read per cycle, back-to-back.
- rd_release with full_count != 0: toggle rd_bank, full_count -= 1. rd_release with full_count == 0 is ignored.
- A read issued in the same cycle as rd_release uses the pre-release bank.
- Frame completion and accepted release in the same cycle: full_count unchanged, both pointers toggle.
- Reset (async assert, sync-safe deassert): wr_bank=rd_bank=0, counters=0, full_count=0, wr_ready=1 after reset, rd_bank_ready=0, wr_frame_done=0, rd_valid=0, rd_data=0, pipeline registers cleared.
- Reset mid-frame discards the partial frame and marks both banks empty. RAM contents are not cleared.
- Width rules: addresses are unsigned; the pixel word is a concatenation of samples, with no arithmetic performed on data.

Test Plan:
- Fill 4x4x3 with sample = c*100+y*10+x, then read pix 0..15 with rd_en held -> each channel matches (e.g. pix 5: ch0=11, ch1=111, ch2=211), rd_valid=1, 1-cycle latency; wr_frame_done pulses once; full_count=1.
- Load frame A, then frame B (sample+1) without release -> full_count=2, wr_ready=0; extra wr_valid stalls. Read pix 0 -> 0,100,200. Release -> pix 0 -> 1,101,201, full_count=1, wr_ready=1.
- rd_addr=16 and rd_addr=31 with rd_en=1 -> rd_data=0, rd_valid=1. rd_en=0 -> rd_data=0, rd_valid=0.
- Read before any frame loaded -> rd_valid=0, rd_data=0. rd_release ignored; full_count stays 0.
- OUTPUT_REGISTER="true", back-to-back reads pix 0,1,2 -> data appears 2 cycles after each request, consecutive cycles, values 0/100/200, 1/101/201, 2/102/202.
- Assert rst_n=0 after 20 of 48 samples, release, then load a full frame -> full_count=1 only after 48 new samples; pix 0 reads the new data.

Source files
------------

// File: rtl/bram_input_pingpong.sv
// Ping-pong input feature-map buffer: byte-serial writer fills one bank while the reader fetches whole pixels from the other.
// Read latency 1 cycle (2 with OUTPUT_REGISTER="true"); the writer stalls via wr_ready while both banks are full.
module bram_input_pingpong #(
  parameter int    DATA_WIDTH      = 8,
  parameter int    IN_CHANNELS     = 3,
  parameter int    IN_WIDTH        = 4,
  parameter int    IN_HEIGHT       = 4,
  parameter string OUTPUT_REGISTER = "false",
  localparam int   NPIX            = IN_WIDTH * IN_HEIGHT,
  localparam int   PIX_AW          = $clog2(NPIX) + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  output logic                              wr_frame_done,
  output logic                              rd_bank_ready,
  input  logic [PIX_AW-1:0]                 rd_addr,
  input  logic                              rd_en,
  output logic [DATA_WIDTH*IN_CHANNELS-1:0] rd_data,
  output logic                              rd_valid,
  input  logic                              rd_release,
  output logic [1:0]                        full_count
);

  localparam int WW  = DATA_WIDTH * IN_CHANNELS;
  localparam int RAW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CW  = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam logic [CW-1:0]  LAST_CH  = CW'(IN_CHANNELS - 1);
  localparam logic [RAW-1:0] LAST_PIX = RAW'(NPIX - 1);

  logic [WW-1:0]  mem [2][NPIX];
  logic [WW-1:0]  ram_q;
  logic [WW-1:0]  asm_q;
  logic [WW-1:0]  asm_nxt;
  logic [CW-1:0]  ch_cnt;
  logic [RAW-1:0] pix_cnt;
  logic           wr_bank;
  logic           rd_bank;
  logic           s1_vld;
  logic           s1_hit;
  logic [WW-1:0]  s1_dat;

  logic           wr_acc;
  logic           pix_wr;
  logic           frame_end;
  logic           rel_ok;
  logic           rd_in_range;
  logic           rd_hit;
  logic           rd_req;
  logic [RAW-1:0] rd_idx;

  assign wr_ready      = (full_count != 2'd2);
  assign rd_bank_ready = (full_count != 2'd0);
  assign wr_acc        = wr_valid & wr_ready;
  assign pix_wr        = wr_acc & (ch_cnt == LAST_CH);
  assign frame_end     = pix_wr & (pix_cnt == LAST_PIX);
  assign rel_ok        = rd_release & rd_bank_ready;
  assign rd_in_range   = (rd_addr < PIX_AW'(NPIX));
  assign rd_req        = rd_en & rd_bank_ready;
  assign rd_hit        = rd_req & rd_in_range;
  assign rd_idx        = rd_addr[RAW-1:0];

  // The final sample of a pixel goes straight into the RAM word, bypassing asm_q.
  always_comb begin
    asm_nxt = asm_q;
    for (int c = 0; c < IN_CHANNELS; c++) begin
      if (ch_cnt == CW'(c)) asm_nxt[c*DATA_WIDTH +: DATA_WIDTH] = wr_data;
    end
  end

  // Writer and reader never share a bank while a read is allowed, so no collision handling.
  always_ff @(posedge clk) begin
    if (pix_wr) mem[wr_bank][pix_cnt] <= asm_nxt;
    if (rd_hit) ram_q <= mem[rd_bank][rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_cnt        <= '0;
      pix_cnt       <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      full_count    <= 2'd0;
      asm_q         <= '0;
      wr_frame_done <= 1'b0;
      s1_vld        <= 1'b0;
      s1_hit        <= 1'b0;
    end else begin
      wr_frame_done <= frame_end;
      s1_vld        <= rd_req;
      s1_hit        <= rd_hit;
      if (wr_acc) begin
        asm_q <= asm_nxt;
        if (pix_wr) begin
          ch_cnt <= '0;
          if (frame_end) begin
            pix_cnt <= '0;
            wr_bank <= ~wr_bank;
          end else begin
            pix_cnt <= pix_cnt + 1'b1;
          end
        end else begin
          ch_cnt <= ch_cnt + 1'b1;
        end
      end
      if (rel_ok) rd_bank <= ~rd_bank;
      case ({frame_end, rel_ok})
        2'b10:   full_count <= full_count + 2'd1;
        2'b01:   full_count <= full_count - 2'd1;
        default: full_count <= full_count;
      endcase
    end
  end

  // Padding reads keep s1_hit low, so they return zero with valid set.
  assign s1_dat = s1_hit ? ram_q : '0;

  if (OUTPUT_REGISTER == "true") begin : g_oreg
    logic [WW-1:0] o_dat;
    logic          o_vld;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        o_dat <= '0;
        o_vld <= 1'b0;
      end else begin
        o_dat <= s1_dat;
        o_vld <= s1_vld;
      end
    end
    assign rd_data  = o_dat;
    assign rd_valid = o_vld;
  end else begin : g_noreg
    assign rd_data  = s1_dat;
    assign rd_valid = s1_vld;
  end

endmodule

// File: tb/tb_bram_input_pingpong.sv
// Directed bench: one instance without and one with the output register, sharing all inputs.
module tb_bram_input_pingpong;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic [4:0]  rd_addr;
  logic        rd_en;
  logic        rd_release;

  logic        wr_ready, wr_frame_done, rd_bank_ready, rd_valid;
  logic [23:0] rd_data;
  logic [1:0]  full_count;
  logic        wr_ready2, wr_frame_done2, rd_bank_ready2, rd_valid2;
  logic [23:0] rd_data2;
  logic [1:0]  full_count2;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  bram_input_pingpong #(.OUTPUT_REGISTER("false")) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_frame_done(wr_frame_done), .rd_bank_ready(rd_bank_ready),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_release(rd_release), .full_count(full_count));

  bram_input_pingpong #(.OUTPUT_REGISTER("true")) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready2), .wr_frame_done(wr_frame_done2), .rd_bank_ready(rd_bank_ready2),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data2), .rd_valid(rd_valid2),
    .rd_release(rd_release), .full_count(full_count2));

  always @(posedge clk) if (wr_frame_done) done_cnt++;

  typedef struct {
    logic [4:0]  addr;
    logic        en;
    logic [23:0] exp_dat;
    logic        exp_vld;
  } vec_t;
  vec_t vec[20];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_pix(input int p, input int off);
    logic [23:0] r;
    for (int c = 0; c < 3; c++) r[c*8 +: 8] = 8'(c*100 + (p/4)*10 + (p%4) + off);
    return r;
  endfunction

  // Sends samples first..first+n-1 of a frame (sample index = pixel*3 + channel).
  task automatic send_samples(input int off, input int first, input int n, input bit rel_last);
    for (int k = first; k < first + n; k++) begin
      int p = k / 3;
      int c = k % 3;
      int guard = 0;
      wr_data  = 8'(c*100 + (p/4)*10 + (p%4) + off);
      wr_valid = 1'b1;
      rd_release = rel_last && (k == first + n - 1);
      while (!wr_ready && guard < 100) begin
        tick;
        guard++;
      end
      if (guard >= 100) begin
        total++;
        bad++;
        $display("FAIL wr_ready_timeout: got 0 expected 1");
      end
      tick;
    end
    wr_valid   = 1'b0;
    rd_release = 1'b0;
  endtask

  task automatic read1(input int addr, input logic [23:0] exp, input string name);
    rd_en   = 1'b1;
    rd_addr = 5'(addr);
    tick;
    rd_en = 1'b0;
    chk(name, {8'd0, rd_data}, {8'd0, exp});
    chk({name, "_vld"}, {31'd0, rd_valid}, 32'd1);
  endtask

  initial begin
    logic [23:0] prev_dat;
    logic        prev_vld;
    int          d0;

    for (int i = 0; i < 16; i++) vec[i] = '{5'(i), 1'b1, exp_pix(i, 0), 1'b1};
    vec[5]  = '{5'd5, 1'b1, {8'd211, 8'd111, 8'd11}, 1'b1};
    vec[16] = '{5'd16, 1'b1, 24'd0, 1'b1};
    vec[17] = '{5'd31, 1'b1, 24'd0, 1'b1};
    vec[18] = '{5'd5, 1'b0, 24'd0, 1'b0};
    vec[19] = '{5'd0, 1'b0, 24'd0, 1'b0};

    rst_n = 1'b0; wr_data = '0; wr_valid = 1'b0;
    rd_addr = '0; rd_en = 1'b0; rd_release = 1'b0;
    #12;
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_rd_bank_ready", {31'd0, rd_bank_ready}, 32'd0);
    chk("rst_full_count", {30'd0, full_count}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", {8'd0, rd_data}, 32'd0);
    chk("rst_frame_done", {31'd0, wr_frame_done}, 32'd0);
    rst_n = 1'b1;
    tick;

    // Read and release with nothing loaded.
    rd_en = 1'b1; rd_addr = 5'd0; rd_release = 1'b1;
    tick;
    rd_en = 1'b0; rd_release = 1'b0;
    chk("empty_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("empty_rd_data", {8'd0, rd_data}, 32'd0);
    chk("empty_release_fc", {30'd0, full_count}, 32'd0);

    send_samples(0, 0, 48, 1'b0);
    tick; tick;
    chk("frameA_done_pulses", done_cnt, 32'd1);
    chk("frameA_full_count", {30'd0, full_count}, 32'd1);

    // Back-to-back table reads; dut2 lags by one vector.
    prev_dat = '0; prev_vld = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rd_en = vec[i].en; rd_addr = vec[i].addr;
      tick;
      chk($sformatf("tbl%0d_dat", i), {8'd0, rd_data}, {8'd0, vec[i].exp_dat});
      chk($sformatf("tbl%0d_vld", i), {31'd0, rd_valid}, {31'd0, vec[i].exp_vld});
      chk($sformatf("oreg%0d_dat", i), {8'd0, rd_data2}, {8'd0, prev_dat});
      chk($sformatf("oreg%0d_vld", i), {31'd0, rd_valid2}, {31'd0, prev_vld});
      prev_dat = vec[i].exp_dat; prev_vld = vec[i].exp_vld;
    end
    rd_en = 1'b0;

    // Second frame fills the other bank; writer then stalls.
    send_samples(1, 0, 48, 1'b0);
    wr_valid = 1'b1; wr_data = 8'hAA;
    tick; tick; tick;
    chk("both_full_fc", {30'd0, full_count}, 32'd2);
    chk("both_full_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("stall_no_extra_done", done_cnt, 32'd2);
    wr_valid = 1'b0;
    read1(0, {8'd200, 8'd100, 8'd0}, "fullA_pix0");

    // Read issued with release still sees the old bank.
    rd_en = 1'b1; rd_addr = 5'd0; rd_release = 1'b1;
    tick;
    rd_en = 1'b0; rd_release = 1'b0;
    chk("rel_same_cycle_read", {8'd0, rd_data}, {8'd0, 8'd200, 8'd100, 8'd0});
    chk("after_rel_fc", {30'd0, full_count}, 32'd1);
    chk("after_rel_wr_ready", {31'd0, wr_ready}, 32'd1);
    read1(0, {8'd201, 8'd101, 8'd1}, "frameB_pix0");
    read1(15, exp_pix(15, 1), "frameB_pix15");

    // Frame completion coincides with release: count holds, both pointers move.
    send_samples(2, 0, 48, 1'b1);
    tick;
    chk("done_and_rel_fc", {30'd0, full_count}, 32'd1);
    read1(0, exp_pix(0, 2), "frameC_pix0");
    read1(9, exp_pix(9, 2), "frameC_pix9");

    // Reset mid-frame, then a full fresh frame.
    send_samples(5, 0, 20, 1'b0);
    rst_n = 1'b0;
    #3;
    chk("midrst_fc", {30'd0, full_count}, 32'd0);
    chk("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
    tick;
    rst_n = 1'b1;
    rd_release = 1'b1;
    tick;
    rd_release = 1'b0;
    chk("midrst_release_ignored", {30'd0, full_count}, 32'd0);
    d0 = done_cnt;
    send_samples(3, 0, 47, 1'b0);
    tick;
    chk("partial47_fc", {30'd0, full_count}, 32'd0);
    chk("partial47_no_done", done_cnt - d0, 32'd0);
    send_samples(3, 47, 1, 1'b0);
    tick;
    chk("new_frame_fc", {30'd0, full_count}, 32'd1);
    chk("new_frame_done", done_cnt - d0, 32'd1);
    read1(0, {8'd203, 8'd103, 8'd3}, "newframe_pix0");
    read1(10, exp_pix(10, 3), "newframe_pix10");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
